// File: rtl/best_d_pipe_pkg.sv
// Shared helpers for the best-d selector: default theta table, product sizing
// and a constant-foldable clog2.
package best_d_pkg;

  function automatic int unsigned default_theta(input int unsigned t);
    if (t <= 1)      return 8;
    else if (t == 2) return 4;
    else if (t == 3) return 3;
    else if (t <= 5) return 2;
    else             return 1;
  endfunction

  function automatic int unsigned prod_width(input int unsigned n_w,
                                             input int unsigned theta_w);
    return n_w + theta_w;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/best_d_pipe_ceil_log2_enc.sv
// Combinational q -> ceil(log2 q) priority encoder with saturation detect
// against the largest representable d = 2^(D_W-1).
module ceil_log2_enc
  import best_d_pkg::*;
#(
  parameter int unsigned Q_W  = 21,
  parameter int unsigned D_W  = 20,
  parameter int unsigned UR_W = clog2(Q_W + 1)
) (
  input  logic [Q_W-1:0]  q,
  output logic [UR_W-1:0] u_raw,
  output logic            sat
);

  logic [Q_W-1:0] qm1;

  // ceil(log2 q) for q>=2 is one past the top set bit of q-1
  always_comb begin
    qm1   = q - Q_W'(1);
    u_raw = '0;
    if (q > Q_W'(1)) begin
      for (int unsigned i = 0; i < Q_W; i++) begin
        if (qm1[i]) u_raw = UR_W'(i + 1);
      end
    end
  end

  // q > 2^(D_W-1) exactly when its ceiling exponent reaches D_W
  assign sat = (32'(u_raw) >= D_W);

endmodule

// File: rtl/best_d_pipe.sv
// Best-d selector: d = 2^clamp(ceil(log2((n*theta(t)) >> FRAC))) behind a
// valid/ready pipeline with a programmable theta table.
module best_d_pipe
  import best_d_pkg::*;
#(
  parameter int unsigned N_W     = 21,
  parameter int unsigned T_W     = 4,
  parameter int unsigned THETA_W = 4,
  parameter int unsigned FRAC    = 4,
  parameter int unsigned D_W     = 20,
  parameter int unsigned U_W     = 5,
  parameter int unsigned U_MIN   = 2,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_W-1:0]     in_n,
  input  logic [T_W-1:0]     in_t,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_W-1:0]     out_d,
  output logic [U_W-1:0]     out_u,
  output logic               out_sat,
  input  logic               cfg_we,
  input  logic [T_W-1:0]     cfg_addr,
  input  logic [THETA_W-1:0] cfg_theta
);

  localparam int unsigned P_W  = prod_width(N_W, THETA_W);
  localparam int unsigned Q_W  = P_W - FRAC;
  localparam int unsigned UR_W = clog2(Q_W + 1);

  logic               adv;
  logic [THETA_W-1:0] theta_tab [2**T_W];

  logic               s0_valid;
  logic [N_W-1:0]     s0_n;
  logic [THETA_W-1:0] s0_theta;

  logic [P_W-1:0]     prod;
  logic [Q_W-1:0]     prod_q;
  logic [MUL_LAT-1:0] m_valid;
  logic [Q_W-1:0]     m_q [MUL_LAT];

  logic [UR_W-1:0]    enc_u_raw;
  logic               enc_sat;
  int unsigned        u_clamp;

  // Single global enable: the whole pipe stalls while the output is full
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2**T_W; i++)
        theta_tab[T_W'(i)] <= THETA_W'(default_theta(i));
    end else if (cfg_we) begin
      theta_tab[cfg_addr] <= cfg_theta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
    end else if (adv) begin
      s0_valid <= in_valid && in_ready;
      s0_n     <= in_n;
      s0_theta <= theta_tab[in_t];
    end
  end

  assign prod   = {{THETA_W{1'b0}}, s0_n} * {{N_W{1'b0}}, s0_theta};
  assign prod_q = Q_W'(prod >> FRAC);

  // Only q travels down the multiplier chain; the dropped fraction is never needed
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
    end else if (adv) begin
      m_valid[0] <= s0_valid;
      m_q[0]     <= prod_q;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        m_valid[i] <= m_valid[i-1];
        m_q[i]     <= m_q[i-1];
      end
    end
  end

  ceil_log2_enc #(
    .Q_W  (Q_W),
    .D_W  (D_W),
    .UR_W (UR_W)
  ) u_enc (
    .q     (m_q[MUL_LAT-1]),
    .u_raw (enc_u_raw),
    .sat   (enc_sat)
  );

  always_comb begin
    u_clamp = 32'(enc_u_raw);
    if (u_clamp < U_MIN)
      u_clamp = U_MIN;
    else if (u_clamp > D_W - 1)
      u_clamp = D_W - 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_d     <= D_W'(1) << U_MIN;
      out_u     <= U_W'(U_MIN);
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= m_valid[MUL_LAT-1];
      if (m_valid[MUL_LAT-1]) begin
        out_d   <= D_W'(1) << u_clamp;
        out_u   <= U_W'(u_clamp);
        out_sat <= enc_sat;
      end
    end
  end

endmodule
